// File: rtl/exp_scale_unit.sv
// exp_scale_unit: streaming oData = S * exp(x), 11-cycle latency, run-flag gated.
// Define EXP_SATURATE_EN to saturate oData and raise oOvf on overflow.
module exp_scale_unit #(
  parameter int LUT_BITS = 6,
  parameter int LAT      = 11
) (
  input  logic        CLK,
  input  logic        iRst_n,
  input  logic        iStart,
  input  logic        iStop,
  input  logic [17:0] iX,
  input  logic [17:0] iS,
  input  logic        iValid,
  output logic [17:0] oData,
  output logic        oValid,
  output logic        oRun,
  output logic        oOvf
);

  localparam int XL_W = 18 - LUT_BITS;
  localparam int T_W  = XL_W + 20;

  // exp(i / 2^LUT_BITS) as a Q16.48 Taylor sum, rounded to Q2.16
  function automatic logic [17:0] exp_entry(input int i);
    logic [63:0] term;
    logic [63:0] sum;
    term = 64'd1 << 48;
    sum  = term;
    for (int n = 1; n < 20; n++) begin
      term = term * 64'(i) / (64'(n) << LUT_BITS);
      sum  = sum + term;
    end
    return 18'((sum + (64'd1 << 31)) >> 32);
  endfunction

  logic [17:0] rom [2**LUT_BITS];

  for (genvar g = 0; g < 2**LUT_BITS; g++) begin : g_rom
    localparam logic [17:0] ENTRY = exp_entry(g);
    assign rom[g] = ENTRY;
  end

  logic              run;
  logic [LAT:0]      v;
  logic [17:0]       x_0;
  logic [17:0]       s_q [8];
  logic [17:0]       eh_1, eh_2, eh_3;
  logic [XL_W-1:0]   xl_1, xl_2;
  logic [2*XL_W-1:0] sq_2;
  logic [17:0]       el_3;
  logic [35:0]       prod_4;
  logic [17:0]       e_q [3];
  logic [35:0]       p_q [3];
  logic [17:0]       data_q;
  logic              ovf_q;

  logic [T_W-1:0]    t_2;
  logic [17:0]       el_2;
  logic [35:0]       rnd_4;
  logic [17:0]       data_n;
  logic              ovf_n;
  logic              unused_bits;

  // 1 + xl + xl^2/2 built in Q0.37, rounded to Q1.17
  assign t_2  = (T_W'(xl_2) << 19) + T_W'(sq_2) + (T_W'(1) << 19);
  assign el_2 = (18'd1 << 17) + 18'(t_2[T_W-1:20]);

  assign rnd_4 = prod_4 + (36'd1 << 18);

`ifdef EXP_SATURATE_EN
  assign ovf_n  = |p_q[2][35:31];
  assign data_n = ovf_n ? 18'h3FFFF : p_q[2][30:13];
`else
  assign ovf_n  = 1'b0;
  assign data_n = p_q[2][30:13];
`endif

  assign unused_bits = ^{p_q[2][35:31], p_q[2][12:0],
                         rnd_4[18:0], t_2[19:0]};

  always_ff @(posedge CLK or negedge iRst_n) begin
    if (!iRst_n) begin
      run <= 1'b0;
    end else if (iStop) begin
      run <= 1'b0;
    end else if (iStart) begin
      run <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge iRst_n) begin
    if (!iRst_n) begin
      v <= '0;
    end else if (!run) begin
      v <= '0;
    end else begin
      v <= {v[LAT-1:0], iValid};
    end
  end

  always_ff @(posedge CLK or negedge iRst_n) begin
    if (!iRst_n) begin
      x_0    <= '0;
      s_q    <= '{default: '0};
      eh_1   <= '0;
      eh_2   <= '0;
      eh_3   <= '0;
      xl_1   <= '0;
      xl_2   <= '0;
      sq_2   <= '0;
      el_3   <= '0;
      prod_4 <= '0;
      e_q    <= '{default: '0};
      p_q    <= '{default: '0};
      data_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      x_0    <= iX;
      s_q[0] <= iS;
      for (int i = 1; i < 8; i++) begin
        s_q[i] <= s_q[i-1];
      end
      eh_1   <= rom[x_0[17 -: LUT_BITS]];
      xl_1   <= x_0[XL_W-1:0];
      eh_2   <= eh_1;
      xl_2   <= xl_1;
      sq_2   <= (2*XL_W)'(xl_1) * (2*XL_W)'(xl_1);
      eh_3   <= eh_2;
      el_3   <= el_2;
      prod_4 <= 36'(eh_3) * 36'(el_3);
      e_q[0] <= {1'b0, rnd_4[35:19]};
      e_q[1] <= e_q[0];
      e_q[2] <= e_q[1];
      p_q[0] <= 36'(e_q[2]) * 36'(s_q[7]);
      p_q[1] <= p_q[0];
      p_q[2] <= p_q[1];
      data_q <= data_n;
      ovf_q  <= ovf_n;
    end
  end

  assign oRun   = run;
  assign oValid = v[LAT];
  assign oData  = data_q;
  assign oOvf   = ovf_q;

endmodule

// File: tb/tb_exp_scale_unit.sv
// tb_exp_scale_unit: scoreboard bench for exp_scale_unit.
// Expected values come from a real-valued exp() model with per-sample tolerance.
module tb_exp_scale_unit;

  logic        CLK = 1'b0;
  logic        iRst_n = 1'b1;
  logic        iStart = 1'b0;
  logic        iStop = 1'b0;
  logic [17:0] iX = '0;
  logic [17:0] iS = '0;
  logic        iValid = 1'b0;
  logic [17:0] oData;
  logic        oValid;
  logic        oRun;
  logic        oOvf;

  typedef struct {
    int data;
    int tol;
    bit ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  bit   run_model = 1'b0;

  always #5 CLK = ~CLK;

  exp_scale_unit dut (
    .CLK    (CLK),
    .iRst_n (iRst_n),
    .iStart (iStart),
    .iStop  (iStop),
    .iX     (iX),
    .iS     (iS),
    .iValid (iValid),
    .oData  (oData),
    .oValid (oValid),
    .oRun   (oRun),
    .oOvf   (oOvf)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [17:0] x, input logic [17:0] s,
                       input bit vld, input bit exact);
    exp_t   e;
    real    ev;
    longint ei;
    longint p;
    iX = x;
    iS = s;
    iValid = vld;
    if (vld && run_model) begin
      ev = $exp(real'(x) / 262144.0) * 16384.0;
      ei = longint'($rtoi(ev + 0.5));
      p  = ei * longint'(s);
      e.data = int'((p >>> 13) & 64'h3FFFF);
      e.tol  = exact ? 0 : int'(s >> 12) + 1;
      e.ovf  = 1'b0;
`ifdef EXP_SATURATE_EN
      if ((p >>> 31) != 0) begin
        e.data = 'h3FFFF;
        e.tol  = 0;
        e.ovf  = 1'b1;
      end
`endif
      sb.push_back(e);
    end
  endtask

  task automatic start_pulse();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    run_model = 1'b1;
  endtask

  // everything still in flight is dropped by the flush
  task automatic stop_pulse();
    iStop = 1'b1;
    tick();
    iStop = 1'b0;
    run_model = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    #1 iRst_n = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (oRun !== 1'b0 || oValid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: oRun=%b oValid=%b, required 0 0", oRun, oValid);
    end
    checks++;
    if (oData !== 18'h0 || oOvf !== 1'b0) begin
      failures++;
      $display("FAIL reset_data: oData=%h oOvf=%b, required 0 0", oData, oOvf);
    end
    @(negedge CLK);
    iRst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (oRun !== 1'b0 || oValid !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: oRun=%b oValid=%b, required 0 0", oRun, oValid);
    end
  endtask

  task automatic test_single();
    exp_t e;
    int   lat;
    int   seen;
    start_pulse();
    checks++;
    if (oRun !== 1'b1) begin
      failures++;
      $display("FAIL start_run: oRun=%b, required 1", oRun);
    end
    drive(18'h0, 18'h04000, 1'b1, 1'b1);
    tick();
    drive(18'h0, 18'h0, 1'b0, 1'b0);
    lat = 0;
    seen = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (oValid) begin
        seen++;
        if (seen == 1) lat = c;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL single_extra: oValid=1 oData=%h, required no output", oData);
        end else begin
          e = sb.pop_front();
          if (oData !== 18'(e.data) || oOvf !== e.ovf) begin
            failures++;
            $display("FAIL single_data: oData=%h oOvf=%b, required %h oOvf=%b",
                     oData, oOvf, e.data, e.ovf);
          end
        end
      end
    end
    checks++;
    if (lat != 11) begin
      failures++;
      $display("FAIL single_latency: latency=%0d, required 11", lat);
    end
    checks++;
    if (seen != 1) begin
      failures++;
      $display("FAIL single_count: oValid pulses=%0d, required 1", seen);
    end
    sb.delete();
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    int          d;
    int          nout;
    int          first_c;
    int          second_c;
    logic [17:0] xs [3];
    logic [17:0] ss [3];
    xs = '{18'h20000, 18'h3FFFF, 18'h3FFFF};
    ss = '{18'h04000, 18'h04000, 18'h00000};
    nout = 0;
    first_c = -1;
    second_c = -1;
    for (int c = 0; c < 70; c++) begin
      if (c < 3) drive(xs[c], ss[c], 1'b1, 1'b0);
      else if (c < 50) drive(18'($urandom_range(0, 'h3FFFF)),
                             18'($urandom_range('h1000, 'h8000)),
                             ($urandom_range(0, 3) != 0), 1'b0);
      else drive(18'h0, 18'h0, 1'b0, 1'b0);
      tick();
      if (oValid) begin
        nout++;
        if (nout == 1) first_c = c;
        if (nout == 2) second_c = c;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL b2b_extra: oValid=1 oData=%h, required no output", oData);
        end else begin
          e = sb.pop_front();
          d = int'(oData) - e.data;
          if (d < 0) d = -d;
          if ($isunknown(oData) || d > e.tol || oOvf !== e.ovf) begin
            failures++;
            $display("FAIL b2b_data: out#%0d oData=%h oOvf=%b, required %h+/-%0d oOvf=%b",
                     nout, oData, oOvf, e.data, e.tol, e.ovf);
          end
        end
      end
    end
    checks++;
    if (first_c != 11 || second_c != 12) begin
      failures++;
      $display("FAIL b2b_timing: first two outputs at cycles %0d,%0d, required 11,12",
               first_c, second_c);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL b2b_drain: %0d outputs missing, required 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_overflow();
    exp_t e;
    int   d;
    for (int c = 0; c < 20; c++) begin
      if (c == 0) drive(18'h20000, 18'h30000, 1'b1, 1'b0);
      else drive(18'h0, 18'h0, 1'b0, 1'b0);
      tick();
      if (oValid) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL ovf_extra: oValid=1 oData=%h, required no output", oData);
        end else begin
          e = sb.pop_front();
          d = int'(oData) - e.data;
          if (d < 0) d = -d;
          if ($isunknown(oData) || d > e.tol || oOvf !== e.ovf) begin
            failures++;
            $display("FAIL ovf_data: oData=%h oOvf=%b, required %h+/-%0d oOvf=%b",
                     oData, oOvf, e.data, e.tol, e.ovf);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL ovf_drain: %0d outputs missing, required 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_start_stop_same();
    int nval;
    int nrun;
    stop_pulse();
    iStart = 1'b1;
    iStop = 1'b1;
    drive(18'h10000, 18'h04000, 1'b1, 1'b0);
    tick();
    iStart = 1'b0;
    iStop = 1'b0;
    checks++;
    if (oRun !== 1'b0) begin
      failures++;
      $display("FAIL same_cycle_run: oRun=%b, required 0", oRun);
    end
    nval = 0;
    nrun = 0;
    for (int c = 0; c < 20; c++) begin
      drive(18'h10000, 18'h04000, (c < 4), 1'b0);
      tick();
      if (oValid) nval++;
      if (oRun) nrun++;
    end
    checks++;
    if (nval != 0 || nrun != 0) begin
      failures++;
      $display("FAIL same_cycle_idle: oValid cycles=%0d oRun cycles=%0d, required 0 0",
               nval, nrun);
    end
  endtask

  task automatic test_stop_flush();
    exp_t e;
    int   d;
    start_pulse();
    for (int c = 0; c < 7; c++) begin
      drive(18'($urandom_range(0, 'h3FFFF)), 18'h04000, (c < 5), 1'b0);
      tick();
    end
    stop_pulse();
    checks++;
    if (oRun !== 1'b0) begin
      failures++;
      $display("FAIL flush_run: oRun=%b, required 0", oRun);
    end
    for (int phase = 0; phase < 2; phase++) begin
      if (phase == 1) start_pulse();
      for (int c = 0; c < 24; c++) begin
        if (phase == 1 && c < 4)
          drive(18'($urandom_range(0, 'h3FFFF)),
                18'($urandom_range('h2000, 'h6000)), 1'b1, 1'b0);
        else drive(18'h0, 18'h0, 1'b0, 1'b0);
        tick();
        if (oValid) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL flush_extra: phase %0d oValid=1 oData=%h, required no output",
                     phase, oData);
          end else begin
            e = sb.pop_front();
            d = int'(oData) - e.data;
            if (d < 0) d = -d;
            if ($isunknown(oData) || d > e.tol || oOvf !== e.ovf) begin
              failures++;
              $display("FAIL flush_data: oData=%h oOvf=%b, required %h+/-%0d oOvf=%b",
                       oData, oOvf, e.data, e.tol, e.ovf);
            end
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL flush_drain: %0d outputs missing, required 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_async_reset();
    exp_t e;
    int   d;
    for (int phase = 0; phase < 2; phase++) begin
      start_pulse();
      for (int c = 0; c < (phase == 0 ? 14 : 24); c++) begin
        if (phase == 0 || c < 5)
          drive(18'($urandom_range(0, 'h3FFFF)),
                18'($urandom_range('h2000, 'h6000)), 1'b1, 1'b0);
        else drive(18'h0, 18'h0, 1'b0, 1'b0);
        tick();
        if (oValid) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL arst_extra: phase %0d oValid=1 oData=%h, required no output",
                     phase, oData);
          end else begin
            e = sb.pop_front();
            d = int'(oData) - e.data;
            if (d < 0) d = -d;
            if ($isunknown(oData) || d > e.tol || oOvf !== e.ovf) begin
              failures++;
              $display("FAIL arst_data: oData=%h oOvf=%b, required %h+/-%0d oOvf=%b",
                       oData, oOvf, e.data, e.tol, e.ovf);
            end
          end
        end
      end
      if (phase == 0) begin
        checks++;
        if (oValid !== 1'b1) begin
          failures++;
          $display("FAIL arst_pre: oValid=%b, required 1 before reset", oValid);
        end
        #2;
        iRst_n = 1'b0;
        iValid = 1'b0;
        run_model = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (oValid !== 1'b0 || oData !== 18'h0 || oRun !== 1'b0) begin
          failures++;
          $display("FAIL arst_immediate: oValid=%b oData=%h oRun=%b, required 0 0 0",
                   oValid, oData, oRun);
        end
        #2;
        iRst_n = 1'b1;
        tick();
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL arst_drain: %0d outputs missing, required 0", sb.size());
    end
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_start_stop_same();
    test_stop_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
